// File: rtl/time_cascade_counter.sv
// Seconds/minutes/hours cascade counter with run, set and load paths.
// Edge behaviour is chosen by the state held before the edge; set_mode/enable pick the next state.
module time_cascade_counter #(
  parameter int unsigned W       = 6,
  parameter int unsigned SEC_MOD = 60,
  parameter int unsigned MIN_MOD = 60,
  parameter int unsigned HR_MOD  = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         tick,
  input  logic         set_mode,
  input  logic         inc_min,
  input  logic         inc_hr,
  input  logic         load,
  input  logic [1:0]   load_sel,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] sec,
  output logic [W-1:0] min,
  output logic [W-1:0] hr,
  output logic         min_en,
  output logic         hr_en,
  output logic         day_wrap,
  output logic         load_err
);

  if (SEC_MOD < 2) begin : g_bad_sec_mod
    $error("SEC_MOD must be at least 2");
  end
  if (MIN_MOD < 2) begin : g_bad_min_mod
    $error("MIN_MOD must be at least 2");
  end
  if (HR_MOD < 2) begin : g_bad_hr_mod
    $error("HR_MOD must be at least 2");
  end
  if ((SEC_MOD > (1 << W)) || (MIN_MOD > (1 << W)) || (HR_MOD > (1 << W))) begin : g_bad_width
    $error("W too narrow for a modulus");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, SET = 2'd2} state_t;

  localparam logic [W:0]   SEC_M    = (W+1)'(SEC_MOD);
  localparam logic [W:0]   MIN_M    = (W+1)'(MIN_MOD);
  localparam logic [W:0]   HR_M     = (W+1)'(HR_MOD);
  localparam logic [W-1:0] SEC_LAST = W'(SEC_MOD - 1);
  localparam logic [W-1:0] MIN_LAST = W'(MIN_MOD - 1);
  localparam logic [W-1:0] HR_LAST  = W'(HR_MOD - 1);
  localparam logic [W-1:0] ONE      = W'(1);

  state_t       state_q, state_d;
  logic [W-1:0] sec_q, sec_d, min_q, min_d, hr_q, hr_d;
  logic         min_en_q, hr_en_q, day_wrap_q, load_err_q;

  logic load_fits, load_ok, ld_sec, ld_min, ld_hr;
  logic enter_set, in_set, run_tick;
  logic sec_carry, min_carry, hr_carry;

  always_comb begin
    if (set_mode)    state_d = SET;
    else if (enable) state_d = RUN;
    else             state_d = IDLE;

    case (load_sel)
      2'd0:    load_fits = {1'b0, load_val} < SEC_M;
      2'd1:    load_fits = {1'b0, load_val} < MIN_M;
      2'd2:    load_fits = {1'b0, load_val} < HR_M;
      default: load_fits = 1'b0;
    endcase
    load_ok = load && load_fits;
    ld_sec  = load_ok && (load_sel == 2'd0);
    ld_min  = load_ok && (load_sel == 2'd1);
    ld_hr   = load_ok && (load_sel == 2'd2);

    in_set    = (state_q == SET);
    enter_set = set_mode && !in_set;
    // Entering SET clears sec, so a tick on that same edge is meaningless.
    run_tick  = (state_q == RUN) && tick && !enter_set;

    // A loaded field swallows its increment and emits no carry.
    sec_carry = run_tick && (sec_q == SEC_LAST) && !ld_sec;
    min_carry = sec_carry && (min_q == MIN_LAST) && !ld_min;
    hr_carry  = min_carry && (hr_q == HR_LAST) && !ld_hr;

    sec_d = sec_q;
    if (ld_sec)         sec_d = load_val;
    else if (enter_set) sec_d = '0;
    else if (run_tick)  sec_d = (sec_q == SEC_LAST) ? '0 : sec_q + ONE;

    min_d = min_q;
    if (ld_min)
      min_d = load_val;
    else if (sec_carry || (in_set && inc_min))
      min_d = (min_q == MIN_LAST) ? '0 : min_q + ONE;

    hr_d = hr_q;
    if (ld_hr)
      hr_d = load_val;
    else if (min_carry || (in_set && inc_hr))
      hr_d = (hr_q == HR_LAST) ? '0 : hr_q + ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sec_q      <= '0;
      min_q      <= '0;
      hr_q       <= '0;
      min_en_q   <= 1'b0;
      hr_en_q    <= 1'b0;
      day_wrap_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hr_q       <= hr_d;
      min_en_q   <= sec_carry;
      hr_en_q    <= min_carry;
      day_wrap_q <= hr_carry;
      load_err_q <= load && !load_fits;
    end
  end

  assign sec      = sec_q;
  assign min      = min_q;
  assign hr       = hr_q;
  assign min_en   = min_en_q;
  assign hr_en    = hr_en_q;
  assign day_wrap = day_wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_time_cascade_counter.sv
// Directed and randomized checks of time_cascade_counter against an arithmetic time model.
module tb_time_cascade_counter;

  localparam int W = 6;
  localparam int MODS [3] = '{60, 60, 24};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0, tick = 1'b0, set_mode = 1'b0;
  logic         inc_min = 1'b0, inc_hr = 1'b0, load = 1'b0;
  logic [1:0]   load_sel = 2'd0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] sec, min, hr;
  logic         min_en, hr_en, day_wrap, load_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0 idle, 1 run, 2 set; fields as plain integers.
  int m_mode = 0;
  int m_f [3] = '{0, 0, 0};
  int m_pulse [4] = '{0, 0, 0, 0};

  time_cascade_counter #(.W(W), .SEC_MOD(60), .MIN_MOD(60), .HR_MOD(24)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .tick(tick), .set_mode(set_mode),
    .inc_min(inc_min), .inc_hr(inc_hr), .load(load), .load_sel(load_sel),
    .load_val(load_val), .sec(sec), .min(min), .hr(hr), .min_en(min_en),
    .hr_en(hr_en), .day_wrap(day_wrap), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time advances as a mixed-radix sum, carries are integer quotients.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = 0;
        m_f = '{0, 0, 0};
        m_pulse = '{0, 0, 0, 0};
      end else begin
        int  sel, carry, t;
        bit  valid, entering;
        int  nf [3];
        int  cout [3];
        sel      = int'(load_sel);
        valid    = load && (sel != 3) && (sel < 3 ? int'(load_val) < MODS[sel] : 1'b0);
        entering = set_mode && (m_mode != 2);
        carry    = (m_mode == 1 && tick && !entering) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
          cout[i] = 0;
          if (valid && sel == i) begin
            nf[i] = int'(load_val);
          end else if (i == 0 && entering) begin
            nf[i] = 0;
          end else if (m_mode == 2) begin
            t = m_f[i] + ((i == 1 && inc_min) || (i == 2 && inc_hr) ? 1 : 0);
            nf[i] = t % MODS[i];
          end else begin
            t = m_f[i] + carry;
            cout[i] = t / MODS[i];
            nf[i] = t % MODS[i];
          end
          carry = cout[i];
        end
        m_f = nf;
        m_pulse[0] = cout[0];
        m_pulse[1] = cout[1];
        m_pulse[2] = cout[2];
        m_pulse[3] = (load && !valid) ? 1 : 0;
        m_mode = set_mode ? 2 : (enable ? 1 : 0);
      end
    end
  end

  // Compare process: outputs are settled at every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("sec", int'(sec), m_f[0]);
      chk("min", int'(min), m_f[1]);
      chk("hr", int'(hr), m_f[2]);
      chk("min_en", int'(min_en), m_pulse[0]);
      chk("hr_en", int'(hr_en), m_pulse[1]);
      chk("day_wrap", int'(day_wrap), m_pulse[2]);
      chk("load_err", int'(load_err), m_pulse[3]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int sel, input int val);
    load = 1'b1;
    load_sel = 2'(sel);
    load_val = W'(val);
    cyc();
    load = 1'b0;
  endtask

  task automatic chk_pulses_zero(input string tag);
    chk({tag, "_min_en"}, int'(min_en), 0);
    chk({tag, "_hr_en"}, int'(hr_en), 0);
    chk({tag, "_day_wrap"}, int'(day_wrap), 0);
    chk({tag, "_load_err"}, int'(load_err), 0);
  endtask

  initial begin
    repeat (2) cyc();
    chk("rst_sec", int'(sec), 0);
    chk("rst_min", int'(min), 0);
    chk("rst_hr", int'(hr), 0);
    chk_pulses_zero("rst");
    rst_n = 1'b1;
    cyc();

    // Asynchronous reset mid-count.
    do_load(2, 5);
    do_load(1, 7);
    do_load(0, 9);
    enable = 1'b1;
    cyc();
    chk("pre_rst_time", int'(hr) * 3600 + int'(min) * 60 + int'(sec), 5 * 3600 + 7 * 60 + 9);
    tick = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_sec", int'(sec), 0);
    chk("async_min", int'(min), 0);
    chk("async_hr", int'(hr), 0);
    chk_pulses_zero("async");
    tick = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();

    // Full-day wrap from 23:59:59.
    do_load(2, 23);
    do_load(1, 59);
    do_load(0, 59);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("wrap_time", int'(hr) + int'(min) + int'(sec), 0);
    chk("wrap_min_en", int'(min_en), 1);
    chk("wrap_hr_en", int'(hr_en), 1);
    chk("wrap_day_wrap", int'(day_wrap), 1);
    cyc();
    chk_pulses_zero("wrap_after");

    // Rejected then accepted minute load.
    enable = 1'b0;
    cyc();
    do_load(1, 60);
    chk("bad_load_min", int'(min), 0);
    chk("bad_load_err", int'(load_err), 1);
    cyc();
    chk("bad_load_err_clear", int'(load_err), 0);
    do_load(1, 45);
    chk("good_load_min", int'(min), 45);
    chk("good_load_err", int'(load_err), 0);

    // Setting mode increments without carries.
    do_load(0, 30);
    do_load(1, 59);
    do_load(2, 23);
    set_mode = 1'b1;
    cyc();
    chk("set_sec_clear", int'(sec), 0);
    chk("set_min_hold", int'(min), 59);
    inc_min = 1'b1;
    cyc();
    inc_min = 1'b0;
    chk("set_min_wrap", int'(min), 0);
    chk("set_hr_hold", int'(hr), 23);
    chk("set_no_hr_en", int'(hr_en), 0);
    inc_hr = 1'b1;
    cyc();
    inc_hr = 1'b0;
    chk("set_hr_wrap", int'(hr), 0);
    chk("set_no_day_wrap", int'(day_wrap), 0);
    set_mode = 1'b0;

    // Load collides with a seconds wrap.
    enable = 1'b1;
    do_load(1, 10);
    do_load(0, 59);
    tick = 1'b1;
    do_load(0, 10);
    tick = 1'b0;
    chk("coll_sec", int'(sec), 10);
    chk("coll_min", int'(min), 10);
    chk("coll_min_en", int'(min_en), 0);

    // Idle gating of all strobes.
    enable = 1'b0;
    cyc();
    tick = 1'b1;
    inc_min = 1'b1;
    inc_hr = 1'b1;
    repeat (3) cyc();
    tick = 1'b0;
    inc_min = 1'b0;
    inc_hr = 1'b0;
    chk("gate_sec", int'(sec), 10);
    chk("gate_min", int'(min), 10);
    chk("gate_hr", int'(hr), 0);
    chk_pulses_zero("gate");

    // Randomized run; modes held in short bursts, loads biased toward field limits.
    for (int n = 0; n < 4000; n++) begin
      if (n % 24 == 0) begin
        enable   = ($urandom % 5) != 0;
        set_mode = ($urandom % 5) == 0;
      end
      tick    = ($urandom % 3) != 0;
      inc_min = ($urandom % 3) == 0;
      inc_hr  = ($urandom % 4) == 0;
      load    = ($urandom % 6) == 0;
      load_sel = 2'($urandom % 4);
      case ($urandom % 3)
        0: load_val = W'($urandom % 64);
        1: load_val = W'(load_sel == 2'd2 ? 23 : 59);
        default: load_val = W'(load_sel == 2'd2 ? 24 : 60);
      endcase
      if (!rst_n) rst_n = 1'b1;
      else if (($urandom % 400) == 0) begin
        #2 rst_n = 1'b0;
      end
      cyc();
    end
    load = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
